// File: rtl/pipe_chain_if.sv
// pipe_chain_if: valid/ready stream carrying a WIDTH-bit payload.
// master drives valid/data and samples ready; slave does the reverse.
interface pipe_chain_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: elastic register chain with per-stage hold and flush,
// bubble collapse and a saturating count of killed beats.
// Ports: clk; reset (async, active low); up (stream in, stage 0);
// down (stream out, stage STAGES-1); hold/flush (per stage, bit 0 is
// youngest); stage_valid, occupancy, kill_cnt (status).
module pipe_chain #(
    parameter int WIDTH      = 16,
    parameter int STAGES     = 4,
    parameter bit FLUSH_ZERO = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    pipe_chain_if.slave                 up,
    pipe_chain_if.master                down,
    input  logic [STAGES-1:0]           hold,
    input  logic [STAGES-1:0]           flush,
    output logic [STAGES-1:0]           stage_valid,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]            kill_cnt
);
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int SUM_W = CNT_W + OCC_W + 1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ev;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] nv;
    logic [WIDTH-1:0]  d     [STAGES];
    logic [WIDTH-1:0]  src_d [STAGES];
    logic [WIDTH-1:0]  nd    [STAGES];
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  kills;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  kill_nxt;

    assign ev = v & ~flush;

    // Stall ripples from the output end back towards stage 0.
    always_comb begin : stall_chain
        logic s;
        s = hold[STAGES-1] | (ev[STAGES-1] & ~down.ready);
        stall[STAGES-1] = s;
        for (int i = STAGES - 2; i >= 0; i--) begin
            s = hold[i] | (ev[i] & s);
            stall[i] = s;
        end
    end

    always_comb begin
        src_v[0] = up.valid;
        src_d[0] = up.data;
        for (int i = 1; i < STAGES; i++) begin
            // A held stage keeps its beat, so the stage after it
            // takes a bubble rather than a copy.
            src_v[i] = ev[i-1] & ~hold[i-1];
            src_d[i] = d[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            nv[i] = stall[i] ? ev[i] : src_v[i];
            nd[i] = stall[i] ? d[i] : src_d[i];
            if (FLUSH_ZERO && !nv[i]) begin
                nd[i] = '0;
            end
        end
    end

    always_comb begin
        occ   = '0;
        kills = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (v[i]) begin
                occ = occ + OCC_W'(1);
            end
            if (v[i] & flush[i]) begin
                kills = kills + OCC_W'(1);
            end
        end
        sum = SUM_W'(kill_cnt) + SUM_W'(kills);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            kill_nxt = '1;
        end else begin
            kill_nxt = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v        <= '0;
            kill_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else begin
            v        <= nv;
            kill_cnt <= kill_nxt;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= nd[i];
            end
        end
    end

    assign up.ready    = ~stall[0];
    assign down.valid  = ev[STAGES-1] & ~hold[STAGES-1];
    assign down.data   = d[STAGES-1];
    assign stage_valid = v;
    assign occupancy   = occ;
endmodule
